// File: rtl/car_types_pkg.sv
// Shared types and default timing for the crossroad datapath and its phase scheduler.
package car_types_pkg;

  typedef logic [3:0] car_counter_t;

  typedef enum logic [1:0] {
    A_GREEN,
    A_CLEAR,
    B_GREEN,
    B_CLEAR
  } sched_phase_t;

  localparam int SCHED_MIN_GREEN   = 4;
  localparam int SCHED_MAX_GREEN   = 10;
  localparam int SCHED_CLEAR_TICKS = 2;
  localparam int SCHED_CAR_GAP     = 2;
  localparam int SCHED_TIMER_W     = 4;

  function automatic sched_phase_t sched_next_phase(input sched_phase_t p);
    case (p)
      A_GREEN: return A_CLEAR;
      A_CLEAR: return B_GREEN;
      B_GREEN: return B_CLEAR;
      default: return A_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/car_crossroad_scheduler_if.sv
// Bundle between the scheduler and its surroundings: lane demand and tick in, phase pulses and debug out.
interface car_crossroad_scheduler_if
  import car_types_pkg::*;
#(
  parameter int TIMER_W = SCHED_TIMER_W
) ();

  logic               tick_in;
  car_counter_t       car_counter_a1;
  car_counter_t       car_counter_a2;
  car_counter_t       car_counter_b1;
  car_counter_t       car_counter_b2;
  logic               crossroad_status_changed_out;
  logic               signal_car_to_cross_if_green_out;
  sched_phase_t       phase;
  logic [TIMER_W-1:0] phase_timer;

  modport master (
    output tick_in, car_counter_a1, car_counter_a2, car_counter_b1, car_counter_b2,
    input  crossroad_status_changed_out, signal_car_to_cross_if_green_out, phase, phase_timer
  );

  modport slave (
    input  tick_in, car_counter_a1, car_counter_a2, car_counter_b1, car_counter_b2,
    output crossroad_status_changed_out, signal_car_to_cross_if_green_out, phase, phase_timer
  );

endinterface

// File: rtl/car_crossroad_scheduler_timer.sv
// Tick-enabled counter with synchronous clear that either saturates at or wraps after `limit`.
module sched_tick_timer #(
  parameter int W    = 4,
  parameter bit WRAP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         at_limit
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign at_limit = (count_q == limit);
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      if (clr) begin
        count_d = '0;
      end else if (at_limit) begin
        count_d = WRAP ? '0 : count_q;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/car_crossroad_scheduler.sv
// Demand-aware phase controller: times greens and all-clears and paces car releases on green.
module car_crossroad_scheduler
  import car_types_pkg::*;
#(
  parameter int MIN_GREEN   = SCHED_MIN_GREEN,
  parameter int MAX_GREEN   = SCHED_MAX_GREEN,
  parameter int CLEAR_TICKS = SCHED_CLEAR_TICKS,
  parameter int CAR_GAP     = SCHED_CAR_GAP,
  parameter int TIMER_W     = SCHED_TIMER_W
) (
  input logic                       clk,
  input logic                       rst,
  car_crossroad_scheduler_if.slave  sched_if
);

  localparam int GAP_W = (CAR_GAP > 1) ? $clog2(CAR_GAP) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LIM = TIMER_W'(MAX_GREEN);
  localparam logic [GAP_W-1:0]   GAP_LIM   = GAP_W'(CAR_GAP - 1);
  localparam logic [TIMER_W:0]   MIN_N     = (TIMER_W + 1)'(MIN_GREEN);
  localparam logic [TIMER_W:0]   MAX_N     = (TIMER_W + 1)'(MAX_GREEN);
  localparam logic [TIMER_W:0]   CLEAR_N   = (TIMER_W + 1)'(CLEAR_TICKS);

  sched_phase_t       phase_q, phase_d;
  logic               changed_q, changed_d;
  logic               release_q, release_d;
  logic               timer_clr, gap_clr;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_sat_unused;
  logic [GAP_W-1:0]   gap_count_unused;
  logic               gap_at_limit;
  logic               a_dem, b_dem, dir_b, is_green, own, other, switch_now, clear_done;
  logic [TIMER_W:0]   n;

  sched_tick_timer #(.W(TIMER_W), .WRAP(1'b0)) u_phase_timer (
    .clk(clk), .rst(rst), .en(sched_if.tick_in), .clr(timer_clr),
    .limit(TIMER_LIM), .count(timer_count), .at_limit(timer_sat_unused)
  );

  sched_tick_timer #(.W(GAP_W), .WRAP(1'b1)) u_gap_timer (
    .clk(clk), .rst(rst), .en(sched_if.tick_in), .clr(gap_clr),
    .limit(GAP_LIM), .count(gap_count_unused), .at_limit(gap_at_limit)
  );

  // The timer saturates at MAX_GREEN, so n still clears MAX_N on every tick of a held green.
  always_comb begin
    a_dem      = (sched_if.car_counter_a1 != '0) | (sched_if.car_counter_a2 != '0);
    b_dem      = (sched_if.car_counter_b1 != '0) | (sched_if.car_counter_b2 != '0);
    dir_b      = (phase_q == B_GREEN) | (phase_q == B_CLEAR);
    is_green   = (phase_q == A_GREEN) | (phase_q == B_GREEN);
    own        = dir_b ? b_dem : a_dem;
    other      = dir_b ? a_dem : b_dem;
    n          = {1'b0, timer_count} + (TIMER_W + 1)'(1);
    switch_now = is_green & other & (((n >= MIN_N) & !own) | (n >= MAX_N));
    clear_done = !is_green & (n >= CLEAR_N);

    phase_d   = phase_q;
    changed_d = 1'b0;
    release_d = 1'b0;
    timer_clr = 1'b0;
    gap_clr   = 1'b0;

    if (sched_if.tick_in) begin
      if (is_green) begin
        if (switch_now) begin
          phase_d   = sched_next_phase(phase_q);
          changed_d = 1'b1;
          timer_clr = 1'b1;
          gap_clr   = 1'b1;
        end else begin
          release_d = own & gap_at_limit;
        end
      end else begin
        gap_clr = 1'b1;
        if (clear_done) begin
          phase_d   = sched_next_phase(phase_q);
          changed_d = 1'b1;
          timer_clr = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= A_GREEN;
      changed_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      changed_q <= changed_d;
      release_q <= release_d;
    end
  end

  assign sched_if.phase                            = phase_q;
  assign sched_if.phase_timer                      = timer_count;
  assign sched_if.crossroad_status_changed_out     = changed_q;
  assign sched_if.signal_car_to_cross_if_green_out = release_q;

endmodule
